// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared widths and the empty-request code for the 4-to-2 priority encoder
package prio_enc_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] CODE_NONE = 2'b00;
endpackage

// File: rtl/prio_enc_4_2_core.sv
// prio_enc_4_2_core: combinational Boolean equations for the 4-to-2 priority encoder, bit 3 highest
module prio_enc_4_2_core
  import prio_enc_pkg::*;
(
  input  logic [N_REQ-1:0] c_i,
  output logic [IDX_W-1:0] code_o,
  output logic             valid_o
);
  logic [IDX_W-1:0] eq;
  // Encode the highest set bit; an empty request yields CODE_NONE
  always_comb begin
    eq[1]   = c_i[3] | c_i[2];
    eq[0]   = c_i[3] | (~c_i[2] & c_i[1]);
    valid_o = |c_i;
    code_o  = valid_o ? eq : CODE_NONE;
  end
endmodule

// File: rtl/priority_enc_4_2_equation.sv
// priority_enc_4_2_equation: priority encoder core with an optional one-cycle output register
module priority_enc_4_2_equation
  import prio_enc_pkg::*;
#(
  parameter bit OUT_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_code,
  output logic [IDX_W-1:0] o_code,
  output logic             o_valid
);
  logic [IDX_W-1:0] code_d;
  logic             valid_d;
  prio_enc_4_2_core u_core (
    .c_i     (i_code),
    .code_o  (code_d),
    .valid_o (valid_d)
  );
  if (OUT_REG) begin : g_reg
    logic [IDX_W-1:0] code_q;
    logic             valid_q;
    // Register the encoder result; reset wins over the sampled request
    always_ff @(posedge i_clk) begin
      code_q  <= i_rst ? CODE_NONE : code_d;
      valid_q <= i_rst ? 1'b0 : valid_d;
    end
    assign o_code  = code_q;
    assign o_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = ^{i_clk, i_rst};
    assign o_code  = code_d;
    assign o_valid = valid_d;
  end
endmodule

// File: tb/tb_priority_enc_4_2_equation.sv
// tb_priority_enc_4_2_equation: directed table-driven check of registered and combinational encoders
module tb_priority_enc_4_2_equation;
  typedef struct {
    logic [3:0] c;
    logic [1:0] code;
    logic       v;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst, rst0;
  logic [3:0] code, code0;
  logic [1:0] oc, oc0;
  logic       ov, ov0;
  int         total = 0;
  int         bad = 0;
  vec_t       vec [18];
  priority_enc_4_2_equation #(.OUT_REG(1)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_code(code), .o_code(oc), .o_valid(ov)
  );
  priority_enc_4_2_equation #(.OUT_REG(0)) dut_c (
    .i_clk(clk), .i_rst(rst0), .i_code(code0), .o_code(oc0), .o_valid(ov0)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [1:0] gc, input logic gv,
                       input logic [1:0] ec, input logic ev);
    total++;
    if (gc !== ec || gv !== ev) begin
      bad++;
      $display("FAIL %s: got code=%b valid=%b, want code=%b valid=%b", name, gc, gv, ec, ev);
    end
  endtask
  initial begin
    for (int i = 0; i < 18; i++) begin
      vec[i].c = 4'(i % 16);
      vec[i].v = (i % 16) != 0;
      vec[i].code = (i % 16) >= 8 ? 2'b11 : (i % 16) >= 4 ? 2'b10 : (i % 16) >= 2 ? 2'b01 : 2'b00;
    end
    rst = 1'b1; rst0 = 1'b0; code = 4'hF; code0 = 4'h0;
    tick();
    tick();
    check("reset", oc, ov, 2'b00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      code = vec[i].c;
      tick();
      check($sformatf("sweep%0d", i), oc, ov, vec[i].code, vec[i].v);
    end
    code = 4'b0001;
    tick();
    check("prio_low", oc, ov, 2'b00, 1'b1);
    code = 4'b1001;
    tick();
    check("prio_override", oc, ov, 2'b11, 1'b1);
    code = 4'b0100; rst = 1'b1;
    tick();
    check("midrst_on", oc, ov, 2'b00, 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_off", oc, ov, 2'b10, 1'b1);
    code = 4'b0010;
    #2;
    check("latency_hold", oc, ov, 2'b10, 1'b1);
    @(negedge clk);
    check("latency_hold2", oc, ov, 2'b10, 1'b1);
    tick();
    check("latency_update", oc, ov, 2'b01, 1'b1);
    for (int i = 0; i < 18; i++) begin
      code0 = vec[i].c;
      #1;
      check($sformatf("comb%0d", i), oc0, ov0, vec[i].code, vec[i].v);
      rst0 = ~rst0;
      tick();
      check($sformatf("comb_rst%0d", i), oc0, ov0, vec[i].code, vec[i].v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
